block_bank_ctrl: RTL and testbench
==================================

Name: block_bank_ctrl

Overview:
- Sequences a bank of NBLK 16-bit cache storage blocks and shares them between two requesters.
- Each block has a level-sensitive enable/ack interface: ack rises after enable rises and clears when enable falls.
- This controller turns that interface into a clocked 4-phase transaction and arbitrates the two ports round-robin.
- It also provides a bank-wide clear sweep and an ack timeout. It sits between the cache front-end ports and the block array.

Parameters:
- NBLK, 8: number of storage blocks in the bank; 2..256.
- AW, 3: address width; must satisfy 2**AW >= NBLK.
- TIMEOUT, 15: cycles to wait for a block ack edge before aborting with an error; 1..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- req  in  2  per-port request level; held until that port's resp_valid.
- req_write  in  2  per-port op: 1 = write, 0 = read; stable while req is high.
- req_addr0  in  AW  port 0 block index.
- req_addr1  in  AW  port 1 block index.
- req_wdata0  in  16  port 0 write data.
- req_wdata1  in  16  port 1 write data.
- resp_valid  out  2  one-cycle completion pulse, per port.
- resp_rdata  out  16  data read back from the block; valid with resp_valid, held until the next response.
- resp_err  out  1  qualifies resp_valid; 1 = bad address or timeout.
- clear_req  in  1  pulse; requests a zeroing sweep of all blocks.
- clear_busy  out  1  high from acceptance of clear_req until the sweep completes.
- blk_enable  out  NBLK  one-hot enable to the addressed block.
- blk_write  out  1  shared write strobe to the blocks.
- blk_rst  out  1  shared zeroing strobe to the blocks.
- blk_wdata  out  16  shared write data to the blocks.
- blk_rdata  in  NBLK*16  concatenated block data_out; block i occupies bits [16i+15:16i].
- blk_ack  in  NBLK  per-block ack.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, round-robin pointer = 0, clear-pending flag = 0.
- Reset mid-transaction aborts the transaction immediately. No resp_valid is issued for it.
- All outputs are registered.

FSM states: IDLE, ASSERT, RELEASE, DONE, CLR_ASSERT, CLR_RELEASE.

IDLE:
- If clear is pending, load sweep index = 0 and go to CLR_ASSERT.
- Else, if any req bit is high, grant one port:
  - Round-robin: the pointer names the preferred port; an alone requester wins.
  - After each grant the pointer moves to the other port.
- Latch the granted port's op, addr and wdata.
- If addr >= NBLK, go to DONE with err = 1 and no block access.
- Otherwise go to ASSERT.

ASSERT:
- Drive blk_enable[addr] = 1, blk_write = op, blk_rst = 0, blk_wdata = latched data.
- Wait for blk_ack[addr] = 1, then capture the addressed blk_rdata slice into resp_rdata and go to RELEASE.

RELEASE:
- Drive blk_enable = 0 and blk_write = 0.
- Wait for blk_ack[addr] = 0, then go to DONE.

DONE:
- Pulse resp_valid[granted port] for exactly one cycle, with resp_err as determined.
- Return to IDLE.
- The requester drops req on the cycle it sees resp_valid. The controller ignores that port's req in the cycle after DONE, so there is no double grant.

Timeout:
- A cycle counter runs in ASSERT and in RELEASE, reset on each state entry.
- If it reaches TIMEOUT:
  - In ASSERT: drop enable, set err = 1, and go to RELEASE.
  - In RELEASE: go to DONE with err = 1 and leave resp_rdata unchanged.

Clear:
- A clear_req pulse sets the pending flag and clear_busy, in any state.
- An in-flight transaction finishes first. Clear then takes priority over requests in IDLE.
- Sweep: for each index 0..NBLK-1, CLR_ASSERT drives blk_enable[i] = 1 and blk_rst = 1, waits for ack, then CLR_RELEASE drops enable and waits for ack low. The index then increments.
- Timeouts in the sweep are skipped silently and the sweep moves on.
- After index NBLK-1: clear the pending flag, clear_busy = 0, go to IDLE.
- A clear_req arriving during a sweep is absorbed; no second sweep is run.

Latency:
- Minimum grant to resp_valid is 4 cycles (IDLE, ASSERT, RELEASE, DONE), with ack responding within one cycle.
- A bad-address response takes 2 cycles.

Decomposition:
- Shared package cache_pkg holds:
  - the FSM state encoding (3-bit);
  - data width constant WORD = 16;
  - port count NPORT = 2.
- One natural sub-module, rr_arbiter2: 2-input round-robin grant with a pointer update on accept.

Test Plan:
- Port 0 write addr 3, data 16'hBEEF; then port 0 read addr 3. Expected: the read's resp_valid[0] with resp_rdata = 16'hBEEF, err = 0, 4 cycles after grant; blk_enable = 8'b0000_1000 only.
- Both ports request on the same cycle (pointer = 0). Expected: port 0 is served first, then port 1. A repeat of the simultaneous request is served in order port 1, then port 0.
- Port 1 read of addr 9 with NBLK = 8. Expected: resp_valid[1] with err = 1 two cycles after grant; blk_enable stays 0.
- Block 5 model never acks, TIMEOUT = 15. Expected: enable drops after 15 cycles and resp_err = 1. A following access to block 2 succeeds.
- Write 16'h1234 to all blocks, pulse clear_req while port 0 is mid-write. Expected: the write completes, then the sweep runs blocks 0..7 with blk_rst = 1; clear_busy falls; subsequent reads all return 16'h0000.
- Assert rst low while in ASSERT. Expected: all outputs 0 asynchronously, no resp_valid; after release, a fresh request completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache block-bank controller: data width,
// port count, controller state encoding and a port decode helper.
package cache_pkg;

  localparam int WORD  = 16;
  localparam int NPORT = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE        = 3'd0;
  localparam state_t S_ASSERT      = 3'd1;
  localparam state_t S_RELEASE     = 3'd2;
  localparam state_t S_DONE        = 3'd3;
  localparam state_t S_CLR_ASSERT  = 3'd4;
  localparam state_t S_CLR_RELEASE = 3'd5;

  // One-hot response vector for a granted port index.
  function automatic logic [NPORT-1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer names the preferred port when
// both request; a lone requester always wins. On an accepted grant the
// pointer moves to the port that was not granted.
module rr_arbiter2
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic             accept,
  output logic [NPORT-1:0] gnt,
  output logic             gnt_idx
);

  logic ptr;

  // Grant decode: contested requests resolved by the pointer.
  always_comb begin
    gnt = '0;
    if (req[0] && req[1]) gnt = ptr ? 2'b10 : 2'b01;
    else                  gnt = req;
  end

  assign gnt_idx = gnt[1];

  // Pointer update on each accepted grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 ptr <= 1'b0;
    else if (accept && |gnt)  ptr <= ~gnt_idx;
  end

endmodule

// File: rtl/block_bank_ctrl.sv
// Block bank controller: arbitrates two cache ports onto a bank of storage
// blocks with a level enable/ack handshake, runs a 4-phase transaction per
// access, a bank-wide zeroing sweep on request, and aborts on ack timeout.
//
// state         | meaning
// S_IDLE        | start clear sweep if pending, else grant a port
// S_ASSERT      | enable high to addressed block, wait ack high
// S_RELEASE     | enable low, wait ack low
// S_DONE        | one-cycle resp_valid pulse to granted port
// S_CLR_ASSERT  | enable + blk_rst high to sweep block, wait ack high
// S_CLR_RELEASE | enable low, wait ack low, advance sweep index
module block_bank_ctrl
  import cache_pkg::*;
#(
  parameter int NBLK    = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT-1:0]     req,
  input  logic [NPORT-1:0]     req_write,
  input  logic [AW-1:0]        req_addr0,
  input  logic [AW-1:0]        req_addr1,
  input  logic [WORD-1:0]      req_wdata0,
  input  logic [WORD-1:0]      req_wdata1,
  output logic [NPORT-1:0]     resp_valid,
  output logic [WORD-1:0]      resp_rdata,
  output logic                 resp_err,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic [NBLK-1:0]      blk_enable,
  output logic                 blk_write,
  output logic                 blk_rst,
  output logic [WORD-1:0]      blk_wdata,
  input  logic [NBLK*WORD-1:0] blk_rdata,
  input  logic [NBLK-1:0]      blk_ack
);

  localparam logic [7:0]    TO_LOAD = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST    = AW'(NBLK - 1);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_nxt;
  logic             port;
  logic             err;
  logic [7:0]       cnt;
  logic             clr_pend;
  logic [NPORT-1:0] ign_mask;

  logic [NPORT-1:0] gnt;
  logic             gnt_idx;
  logic             accept;
  logic [AW-1:0]    g_addr;
  logic [WORD-1:0]  g_wdata;
  logic             g_write;
  logic             addr_bad;
  logic             in_sweep;
  logic             ack_sel;
  logic [WORD-1:0]  rdata_sel;

  // One-hot decode of a block index; out-of-range indices decode to zero.
  function automatic logic [NBLK-1:0] dec(input logic [AW-1:0] a);
    logic [NBLK-1:0] v;
    v = '0;
    for (int i = 0; i < NBLK; i++)
      if (a == AW'(i)) v[i] = 1'b1;
    return v;
  endfunction

  // The port just served is masked for one IDLE cycle so its trailing req
  // level cannot earn a second grant.
  assign accept = (state == S_IDLE) && !clr_pend;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req & ~ign_mask),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign g_addr   = gnt_idx ? req_addr1  : req_addr0;
  assign g_wdata  = gnt_idx ? req_wdata1 : req_wdata0;
  assign g_write  = gnt_idx ? req_write[1] : req_write[0];
  assign addr_bad = (int'(g_addr) >= NBLK);
  assign in_sweep = (state == S_CLR_ASSERT) || (state == S_CLR_RELEASE);
  assign idx_nxt  = idx + 1'b1;

  // Select ack and read data of the block currently addressed by idx.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NBLK; i++) begin
      if (idx == AW'(i)) begin
        ack_sel   = blk_ack[i];
        rdata_sel = blk_rdata[i*WORD +: WORD];
      end
    end
  end

  // Controller FSM with registered outputs, timeout down-counter and clear tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      port       <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      clr_pend   <= 1'b0;
      ign_mask   <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      clear_busy <= 1'b0;
      blk_enable <= '0;
      blk_write  <= 1'b0;
      blk_rst    <= 1'b0;
      blk_wdata  <= '0;
    end else begin
      resp_valid <= '0;
      ign_mask   <= '0;
      case (state)
        S_IDLE: begin
          if (clr_pend) begin
            idx        <= '0;
            blk_enable <= dec('0);
            blk_rst    <= 1'b1;
            cnt        <= TO_LOAD;
            state      <= S_CLR_ASSERT;
          end else if (|gnt) begin
            port      <= gnt_idx;
            idx       <= g_addr;
            blk_wdata <= g_wdata;
            if (addr_bad) begin
              err        <= 1'b1;
              resp_valid <= gnt;
              resp_err   <= 1'b1;
              state      <= S_DONE;
            end else begin
              err        <= 1'b0;
              blk_enable <= dec(g_addr);
              blk_write  <= g_write;
              cnt        <= TO_LOAD;
              state      <= S_ASSERT;
            end
          end
        end
        S_ASSERT: begin
          if (ack_sel || cnt == '0) begin
            if (ack_sel) resp_rdata <= rdata_sel;
            else         err        <= 1'b1;
            blk_enable <= '0;
            blk_write  <= 1'b0;
            cnt        <= TO_LOAD;
            state      <= S_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          if (!ack_sel || cnt == '0) begin
            resp_valid <= port_onehot(port);
            resp_err   <= err | ack_sel;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          ign_mask <= port_onehot(port);
          resp_err <= 1'b0;
          state    <= S_IDLE;
        end
        S_CLR_ASSERT: begin
          if (ack_sel || cnt == '0) begin
            blk_enable <= '0;
            blk_rst    <= 1'b0;
            cnt        <= TO_LOAD;
            state      <= S_CLR_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CLR_RELEASE: begin
          if (!ack_sel || cnt == '0) begin
            if (idx == LAST) begin
              clr_pend   <= 1'b0;
              clear_busy <= 1'b0;
              state      <= S_IDLE;
            end else begin
              idx        <= idx_nxt;
              blk_enable <= dec(idx_nxt);
              blk_rst    <= 1'b1;
              cnt        <= TO_LOAD;
              state      <= S_CLR_ASSERT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A clear request during a sweep is absorbed by the sweep in progress.
      if (clear_req && !in_sweep) begin
        clr_pend   <= 1'b1;
        clear_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_block_bank_ctrl.sv
// Directed bench for block_bank_ctrl with a behavioural block-array model.
module tb_block_bank_ctrl;

  localparam int NBLK = 8;
  localparam int AW   = 4;
  localparam int TO   = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic [1:0]         req_write;
  logic [AW-1:0]      req_addr0, req_addr1;
  logic [15:0]        req_wdata0, req_wdata1;
  logic [1:0]         resp_valid;
  logic [15:0]        resp_rdata;
  logic               resp_err;
  logic               clear_req;
  logic               clear_busy;
  logic [NBLK-1:0]    blk_enable;
  logic               blk_write;
  logic               blk_rst;
  logic [15:0]        blk_wdata;
  logic [NBLK*16-1:0] blk_rdata;
  logic [NBLK-1:0]    blk_ack;

  logic [15:0]     mem [NBLK] = '{default: 16'hA5A5};
  logic [NBLK-1:0] dead;
  logic [31:0]     sweep_order = '0;
  int              sweep_n = 0;
  logic [NBLK-1:0] prev_en = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  block_bank_ctrl #(.NBLK(NBLK), .AW(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_write  (req_write),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .blk_enable (blk_enable),
    .blk_write  (blk_write),
    .blk_rst    (blk_rst),
    .blk_wdata  (blk_wdata),
    .blk_rdata  (blk_rdata),
    .blk_ack    (blk_ack)
  );

  // Level-sensitive blocks: ack follows enable unless the block is dead.
  always_comb begin
    blk_ack   = '0;
    blk_rdata = '0;
    for (int i = 0; i < NBLK; i++) begin
      blk_ack[i]            = blk_enable[i] & ~dead[i];
      blk_rdata[i*16 +: 16] = mem[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NBLK; i++)
      if (blk_enable[i] && !dead[i]) begin
        if (blk_rst)        mem[i] <= 16'h0000;
        else if (blk_write) mem[i] <= blk_wdata;
      end
  end

  // Log the order in which blocks are hit with the zeroing strobe.
  always @(negedge clk) begin
    if (blk_rst && blk_enable != '0 && blk_enable != prev_en) begin
      for (int i = 0; i < NBLK; i++)
        if (blk_enable[i]) begin
          sweep_order <= {sweep_order[27:0], 4'(i)};
          sweep_n     <= sweep_n + 1;
        end
    end
    prev_en <= blk_enable;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic wr, input logic [AW-1:0] a, input logic [15:0] d);
    if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
    req_write[p] = wr;
    req[p]       = 1'b1;
  endtask

  // Single-port transaction; lat counts the cycle req is presented through the resp_valid cycle.
  task automatic xact(input int p, input logic wr, input logic [AW-1:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic er, output int lat,
                      output int en_cnt, output logic [NBLK-1:0] en_seen);
    bit got;
    got = 0; rd = '0; er = 1'b0; en_cnt = 0; en_seen = '0;
    repeat (2) @(negedge clk);
    drive_port(p, wr, a, d);
    lat = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      en_seen |= blk_enable;
      if (blk_enable != '0) en_cnt++;
      if (resp_valid[p]) begin
        rd = resp_rdata; er = resp_err; req[p] = 1'b0; got = 1;
        break;
      end
    end
    if (!got) begin
      req[p] = 1'b0;
      chk("resp_wait", 32'(got), 32'd1);
    end
  endtask

  // Both ports request in the same cycle; reports service order and read data.
  task automatic pair(input logic wr, input logic [AW-1:0] a0, input logic [15:0] d0,
                      input logic [AW-1:0] a1, input logic [15:0] d1,
                      output int first, output int second,
                      output logic [15:0] rd0, output logic [15:0] rd1);
    int n;
    n = 0; first = -1; second = -1; rd0 = '0; rd1 = '0;
    repeat (2) @(negedge clk);
    drive_port(0, wr, a0, d0);
    drive_port(1, wr, a1, d1);
    for (int k = 0; k < 100 && n < 2; k++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        if (resp_valid[p] && req[p]) begin
          req[p] = 1'b0;
          if (p == 0) rd0 = resp_rdata; else rd1 = resp_rdata;
          if (n == 0) first = p; else second = p;
          n++;
        end
    end
    req = 2'b00;
    chk("pair_done", 32'(n), 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]     rd, r0, r1, prev;
    logic            er;
    int              lat, en_cnt, f, s;
    logic [NBLK-1:0] en_seen;
    bit              pulsed, saw, done;

    rst = 1'b0; req = '0; req_write = '0; req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0; clear_req = 1'b0; dead = '0;
    repeat (3) @(negedge clk);
    chk("rst_enable", 32'(blk_enable), 32'h0);
    chk("rst_resp", {29'd0, resp_valid, resp_err}, 32'h0);
    chk("rst_strobes", {29'd0, clear_busy, blk_rst, blk_write}, 32'h0);
    chk("rst_data", {resp_rdata, blk_wdata}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // simultaneous writes, pointer at port 0
    pair(1'b1, 4'd1, 16'h1111, 4'd2, 16'h2222, f, s, r0, r1);
    chk("pair1_first", 32'(f), 32'd0);
    chk("pair1_second", 32'(s), 32'd1);

    // port 0 write then read of block 3
    xact(0, 1'b1, 4'd3, 16'hBEEF, rd, er, lat, en_cnt, en_seen);
    chk("wr3_err", 32'(er), 32'd0);
    chk("wr3_lat", 32'(lat), 32'd4);
    xact(0, 1'b0, 4'd3, 16'h0000, rd, er, lat, en_cnt, en_seen);
    chk("rd3_data", 32'(rd), 32'hBEEF);
    chk("rd3_err", 32'(er), 32'd0);
    chk("rd3_lat", 32'(lat), 32'd4);
    chk("rd3_enable", 32'(en_seen), 32'h08);
    chk("rd3_en_cycles", 32'(en_cnt), 32'd1);

    // simultaneous reads now served port 1 first
    pair(1'b0, 4'd1, 16'h0000, 4'd2, 16'h0000, f, s, r0, r1);
    chk("pair2_first", 32'(f), 32'd1);
    chk("pair2_second", 32'(s), 32'd0);
    chk("pair2_rd0", 32'(r0), 32'h1111);
    chk("pair2_rd1", 32'(r1), 32'h2222);

    // out-of-range address
    xact(1, 1'b0, 4'd9, 16'h0000, rd, er, lat, en_cnt, en_seen);
    chk("bad_err", 32'(er), 32'd1);
    chk("bad_lat", 32'(lat), 32'd2);
    chk("bad_enable", 32'(en_seen), 32'h0);

    // block 5 never acks
    prev = resp_rdata;
    dead = 8'h20;
    xact(0, 1'b0, 4'd5, 16'h0000, rd, er, lat, en_cnt, en_seen);
    chk("to_err", 32'(er), 32'd1);
    chk("to_en_cycles", 32'(en_cnt), 32'd15);
    chk("to_rdata_held", 32'(rd), 32'(prev));
    chk("to_lat", 32'(lat), 32'd18);
    dead = '0;
    xact(0, 1'b0, 4'd2, 16'h0000, rd, er, lat, en_cnt, en_seen);
    chk("after_to_data", 32'(rd), 32'h2222);
    chk("after_to_err", 32'(er), 32'd0);

    // fill bank, clear requested during the last write
    for (int i = 0; i < NBLK - 1; i++)
      xact(0, 1'b1, AW'(i), 16'h1234, rd, er, lat, en_cnt, en_seen);
    fork
      xact(0, 1'b1, 4'd7, 16'h1234, rd, er, lat, en_cnt, en_seen);
      begin
        repeat (3) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clr_busy_rise", 32'(clear_busy), 32'd1);
      end
    join
    chk("clr_wr_err", 32'(er), 32'd0);
    chk("clr_wr_lat", 32'(lat), 32'd4);
    chk("clr_wr_before_sweep", 32'(sweep_n), 32'd0);
    pulsed = 0; done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (blk_rst && !pulsed) begin clear_req = 1'b1; pulsed = 1; end
      else clear_req = 1'b0;
      if (!clear_busy) begin done = 1; break; end
    end
    clear_req = 1'b0;
    chk("clr_done", 32'(done), 32'd1);
    repeat (5) @(negedge clk);
    chk("clr_busy_stays_low", 32'(clear_busy), 32'd0);
    chk("sweep_count", 32'(sweep_n), 32'd8);
    chk("sweep_order", sweep_order, 32'h01234567);
    for (int i = 0; i < NBLK; i++) begin
      xact(1, 1'b0, AW'(i), 16'h0000, rd, er, lat, en_cnt, en_seen);
      chk("clr_read", {15'd0, er, rd}, 32'h0);
    end

    // reset in the middle of ASSERT
    @(negedge clk);
    drive_port(0, 1'b1, 4'd4, 16'h4444);
    @(negedge clk);
    chk("pre_rst_enable", 32'(blk_enable), 32'h10);
    #2 rst = 1'b0;
    #1;
    chk("async_enable", 32'(blk_enable), 32'h0);
    chk("async_strobes", {29'd0, blk_write, blk_rst, clear_busy}, 32'h0);
    chk("async_wdata", 32'(blk_wdata), 32'h0);
    req = '0;
    saw = 0;
    repeat (3) begin @(negedge clk); saw |= |resp_valid; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); saw |= |resp_valid; end
    chk("no_resp_after_rst", 32'(saw), 32'd0);
    chk("aborted_write", 32'(mem[4]), 32'h0);
    xact(0, 1'b1, 4'd6, 16'h6666, rd, er, lat, en_cnt, en_seen);
    xact(0, 1'b0, 4'd6, 16'h0000, rd, er, lat, en_cnt, en_seen);
    chk("post_rst_data", 32'(rd), 32'h6666);
    chk("post_rst_lat", 32'(lat), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
